// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-feeder FSM encoding, default FIFO depth
// and inter-character gap, plus a small constant helper for parameter checks.
// Reused by the receive side, so keep the defaults here rather than in a module.
package uart_pkg;

  localparam int DEFAULT_DEPTH      = 16;
  // One bit time at 115200 baud from a 12 MHz clock.
  localparam int DEFAULT_GAP_CYCLES = 104;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } feeder_state_e;

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-two byte FIFO with show-ahead read.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_en, wr_data    enqueue request and byte (ignored while full)
//   rd_en             dequeue the head byte (ignored while empty)
//   rd_data           head byte, valid while empty=0
//   full, empty       decoded from the registered count
//   count             bytes stored, 0..DEPTH
//   overflow          one-cycle pulse after an edge that dropped a write
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rptr_q];

  // Accept/pop qualification and next-state for pointers, count and overflow.
  always_comb begin
    // A write while full is dropped even if a pop frees a slot on the same edge.
    wr_ok_s = wr_en && !full;
    rd_ok_s = rd_en && !empty;
    wptr_d  = wr_ok_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = rd_ok_s ? (rptr_q + AW'(1)) : rptr_q;
    ovf_d   = wr_en && full;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/xmit_feeder.sv
// xmit_feeder: buffered byte source for the UART transmitter. Bytes written
// through wr_en/wr_data are queued in byte_fifo and handed one at a time to
// xmit through the char/sendchar/busy handshake.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_data, wr_en    byte to enqueue and its strobe
//   full, empty       FIFO occupancy flags
//   count             bytes queued (excludes the byte handed to xmit)
//   overflow          one-cycle pulse when a write was dropped
//   tx_char, tx_send  to xmit char / sendchar (registered)
//   tx_busy           from xmit busy
// Build option: define XMIT_FEEDER_GAP_EN to hold the line idle for
// GAP_CYCLES clocks after each character.
module xmit_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = $clog2(DEPTH),
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_char,
  output logic          tx_send,
  input  logic          tx_busy
);

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("xmit_feeder: GAP_CYCLES must be at least 1");
  end

  feeder_state_e state_q, state_d;
  logic [7:0]    tx_char_q, tx_char_d;
  logic          tx_send_q, tx_send_d;
  logic          pop_s;
  logic [7:0]    head_s;
  logic          empty_s;

`ifdef XMIT_FEEDER_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Loaded on DRAIN->GAP; GAP exits when it reaches zero, giving GAP_CYCLES clocks in GAP.
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop_s),
    .rd_data  (head_s),
    .full     (full),
    .empty    (empty_s),
    .count    (count),
    .overflow (overflow)
  );

  assign empty   = empty_s;
  assign tx_char = tx_char_q;
  assign tx_send = tx_send_q;

  // Handshake FSM: next state, pop strobe and registered xmit outputs.
  always_comb begin
    state_d   = state_q;
    tx_char_d = tx_char_q;
    tx_send_d = tx_send_q;
    pop_s     = 1'b0;
`ifdef XMIT_FEEDER_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // tx_char only changes here, so it is stable for the whole character.
        if (!empty_s) begin
          pop_s     = 1'b1;
          tx_char_d = head_s;
          tx_send_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        // busy already high on entry counts as acceptance right away.
        if (tx_busy) begin
          tx_send_d = 1'b0;
          state_d   = ST_DRAIN;
        end else begin
          tx_send_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // No timeout: a stuck busy parks here while the FIFO keeps filling.
        if (!tx_busy) begin
`ifdef XMIT_FEEDER_GAP_EN
          gap_cnt_d = GAP_LOAD;
          state_d   = ST_GAP;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          state_d   = ST_DRAIN;
        end
      end
      ST_GAP: begin
`ifdef XMIT_FEEDER_GAP_EN
        if (gap_cnt_q == '0) begin
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        tx_send_d = 1'b0;
      end
    endcase
  end

  // FSM state and xmit output registers; reset drops tx_send without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_char_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_char_q <= tx_char_d;
      tx_send_q <= tx_send_d;
    end
  end

`ifdef XMIT_FEEDER_GAP_EN
  // Inter-character gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_xmit_feeder.sv
// Self-checking bench for xmit_feeder with a behavioural xmit model.
// Expected bytes are queued when written; bytes the xmit model accepts are
// queued on capture, and the two queues are compared in order.
module tb_xmit_feeder;

  localparam int CHAR_CYC = 6;

  logic       clk;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] tx_char;
  logic       tx_send;
  logic       tx_busy;

  logic       m_busy;
  int         m_cnt;
  logic       force_busy;
  logic       hold_off;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  int vectors;
  int miscompares;

  xmit_feeder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_char  (tx_char),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = m_busy | force_busy;

  // Behavioural xmit: accepts a byte when sendchar is seen while idle, then busy for CHAR_CYC clocks.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end else if (tx_send && !tx_busy && !hold_off) begin
      m_busy <= 1'b1;
      m_cnt  <= CHAR_CYC - 1;
      cap_q.push_back(tx_char);
    end
  end

  task automatic write_byte(input logic [7:0] d, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic drain_check(input int n, input int budget, input string tag);
    int waited;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    waited = 0;
    while (cap_q.size() < n && waited < budget) begin
      @(posedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (cap_q.size() < n) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes, need %0d", tag, cap_q.size(), n);
    end
    while (cap_q.size() > 0) begin
      got_b = cap_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_extra: got byte %h, none expected", tag, got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          miscompares++;
          $display("FAIL %s_order: got %h, need %h", tag, got_b, exp_b);
        end
      end
    end
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (cap_q.size() !== 0 || exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL %s_residue: extra captured %0d, missing %0d, need 0/0", tag, cap_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx_send !== 1'b0 || tx_char !== 8'h00 || count !== 5'd0 ||
        empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: send=%b char=%h count=%0d empty=%b full=%b ovf=%b, need 0/00/0/1/0/0",
               tx_send, tx_char, count, empty, full, overflow);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_byte();
    write_byte(8'h41, 1'b1);
    vectors++;
    if (count !== 5'd1 || tx_send !== 1'b0) begin
      miscompares++;
      $display("FAIL single_write: count=%0d send=%b, need 1/0", count, tx_send);
    end
    @(posedge clk); #1;
    vectors++;
    if (tx_send !== 1'b1 || tx_char !== 8'h41 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL single_pop: send=%b char=%h count=%0d, need 1/41/0", tx_send, tx_char, count);
    end
    @(posedge clk); #1;
    vectors++;
    if (tx_send !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_overlap: send=%b busy=%b, need 1/1", tx_send, tx_busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (tx_send !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: send=%b, need 0", tx_send);
    end
    drain_check(1, 200, "single");
  endtask

  task automatic test_burst();
    int  peak;
    bit  saw_ovf;
    peak    = 0;
    saw_ovf = 1'b0;
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(8'h30 + i), 1'b1);
      if (int'(count) > peak) peak = int'(count);
      if (overflow) saw_ovf = 1'b1;
    end
    vectors++;
    if (peak != 9 && peak != 10) begin
      miscompares++;
      $display("FAIL burst_peak: peak count %0d, need 9 or 10", peak);
    end
    vectors++;
    if (saw_ovf) begin
      miscompares++;
      $display("FAIL burst_overflow: overflow seen=1, need 0");
    end
    drain_check(10, 3000, "burst");
  endtask

  task automatic test_overflow();
    int waited;
    write_byte(8'hAA, 1'b1);
    waited = 0;
    while (!m_busy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    @(negedge clk);
    force_busy = 1'b1;
    drain_check(1, 100, "ovf_prime");
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(8'h60 + i), 1'b1);
    end
    vectors++;
    if (full !== 1'b1 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL ovf_full: full=%b count=%0d, need 1/16", full, count);
    end
    write_byte(8'h7F, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL ovf_pulse: overflow=%b count=%0d, need 1/16", overflow, count);
    end
    @(posedge clk); #1;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_one_cycle: overflow=%b, need 0", overflow);
    end
  endtask

  task automatic test_pop_with_full();
    @(negedge clk);
    force_busy = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (full !== 1'b1 || tx_send !== 1'b0) begin
      miscompares++;
      $display("FAIL popfull_pre: full=%b send=%b, need 1/0", full, tx_send);
    end
    write_byte(8'hEE, 1'b0);
    vectors++;
    if (count !== 5'd15 || overflow !== 1'b1 || tx_send !== 1'b1) begin
      miscompares++;
      $display("FAIL popfull_edge: count=%0d overflow=%b send=%b, need 15/1/1", count, overflow, tx_send);
    end
    drain_check(16, 4000, "popfull");
  endtask

  task automatic test_back_to_back();
    int  cyc;
    int  t_fall;
    int  t_rise;
    bit  prev_busy;
    bit  prev_send;
    int  need;
`ifdef XMIT_FEEDER_GAP_EN
    need = 106;
`else
    need = 2;
`endif
    repeat (120) @(posedge clk);
    write_byte(8'h55, 1'b1);
    write_byte(8'h56, 1'b1);
    cyc = 0; t_fall = -1; t_rise = -1;
    prev_busy = tx_busy;
    prev_send = tx_send;
    while (t_rise < 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (t_fall < 0 && prev_busy && !tx_busy) t_fall = cyc;
      else if (t_fall >= 0 && !prev_send && tx_send) t_rise = cyc;
      prev_busy = tx_busy;
      prev_send = tx_send;
    end
    vectors++;
    if (t_rise < 0 || (t_rise - t_fall) != need) begin
      miscompares++;
      $display("FAIL b2b_interval: busy-fall to send-rise %0d clocks (fall=%0d rise=%0d), need %0d",
               t_rise - t_fall, t_fall, t_rise, need);
    end
    drain_check(2, 600, "b2b");
    repeat (120) @(posedge clk);
  endtask

  task automatic test_reset_mid_send();
    @(negedge clk);
    hold_off = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write_byte(8'(8'h90 + i), 1'b0);
    end
    vectors++;
    if (count !== 5'd5 || tx_send !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_setup: count=%0d send=%b, need 5/1", count, tx_send);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx_send !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async: send=%b count=%0d empty=%b, need 0/0/1", tx_send, count, empty);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    hold_off = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if (cap_q.size() !== 0 || tx_send !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_quiet: captured=%0d send=%b empty=%b, need 0/0/1", cap_q.size(), tx_send, empty);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    force_busy  = 1'b0;
    hold_off    = 1'b0;
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_pop_with_full();
    test_back_to_back();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
